// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types, widths and index helpers for the ROB writeback arbiter.
// Optional perf counters are enabled with ROB_WB_ARB_PERF_EN.
package rob_wb_arbiter_pkg;

    localparam int ROB_ADDR_WIDTH      = 5;
    localparam int DISPATCH_WIDTH      = 2;
    localparam int DISPATCH_ADDR_WIDTH = 1;
    localparam int NUM_WB_REQ          = 4;

    // Completion record as emitted by an FU output stage.
    typedef struct packed {
        logic                           valid;
        logic [ROB_ADDR_WIDTH-1:0]      rob_addr;
        logic [DISPATCH_ADDR_WIDTH-1:0] bank_addr;
    } wb_req_t;

    // Index wrap helpers use explicit compares so non-power-of-two counts wrap correctly.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    function automatic int count_ones(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rob_wb_arbiter_if.sv
// Requester-side handshake and ROB writeback bus for rob_wb_arbiter.
// slave: the arbiter; master: FU stages plus the ROB writeback consumer.
interface rob_wb_arbiter_if #(
    parameter int NUM_REQ         = rob_wb_arbiter_pkg::NUM_WB_REQ,
    parameter int WB_WIDTH        = rob_wb_arbiter_pkg::DISPATCH_WIDTH,
    parameter int ROB_ADDR_WIDTH  = rob_wb_arbiter_pkg::ROB_ADDR_WIDTH,
    parameter int BANK_ADDR_WIDTH = rob_wb_arbiter_pkg::DISPATCH_ADDR_WIDTH
);
    import rob_wb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                      req_valid;
    logic [NUM_REQ-1:0][ROB_ADDR_WIDTH-1:0]  req_rob_addr;
    logic [NUM_REQ-1:0][BANK_ADDR_WIDTH-1:0] req_bank_addr;
    logic [NUM_REQ-1:0]                      req_ready;

    logic [WB_WIDTH-1:0]                      wb_en;
    logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]  wb_rob_addr;
    logic [WB_WIDTH-1:0][BANK_ADDR_WIDTH-1:0] wb_bank_addr;

    modport slave (
        input  req_valid, req_rob_addr, req_bank_addr,
        output req_ready, wb_en, wb_rob_addr, wb_bank_addr
    );

    modport master (
        output req_valid, req_rob_addr, req_bank_addr,
        input  req_ready, wb_en, wb_rob_addr, wb_bank_addr
    );

endinterface

// File: rtl/rob_wb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker: selects up to WB_WIDTH requesters starting at ptr,
// the k-th pick in scan order driving port k.
module rob_wb_arbiter_rr_multi_picker #(
    parameter int NUM_REQ  = 4,
    parameter int WB_WIDTH = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]               req,
    input  logic [PTR_W-1:0]                 ptr,
    output logic [WB_WIDTH-1:0][NUM_REQ-1:0] port_sel,
    output logic [WB_WIDTH-1:0]              port_valid,
    output logic [PTR_W-1:0]                 last_idx,
    output logic                             any_grant
);
    import rob_wb_arbiter_pkg::*;

    always_comb begin
        logic [PTR_W-1:0] idx_n;
        int               cnt;
        port_sel   = '0;
        port_valid = '0;
        last_idx   = ptr;
        cnt        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_n = PTR_W'(wrap_idx(int'(ptr) + k, NUM_REQ));
            if (req[idx_n] && cnt < WB_WIDTH) begin
                for (int p = 0; p < WB_WIDTH; p++) begin
                    if (cnt == p) begin
                        port_sel[p][idx_n] = 1'b1;
                        port_valid[p]      = 1'b1;
                    end
                end
                last_idx = idx_n;
                cnt      = cnt + 1;
            end
        end
        any_grant = |port_valid;
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the ROB writeback ports among FU completion requesters.
// Define ROB_WB_ARB_PERF_EN to add saturating grant/conflict counters.
module rob_wb_arbiter #(
    parameter int NUM_REQ         = rob_wb_arbiter_pkg::NUM_WB_REQ,
    parameter int WB_WIDTH        = rob_wb_arbiter_pkg::DISPATCH_WIDTH,
    parameter int ROB_ADDR_WIDTH  = rob_wb_arbiter_pkg::ROB_ADDR_WIDTH,
    parameter int BANK_ADDR_WIDTH = rob_wb_arbiter_pkg::DISPATCH_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
`ifdef ROB_WB_ARB_PERF_EN
    output logic [31:0] perf_grant_cnt,
    output logic [31:0] perf_conflict_cnt,
`endif
    rob_wb_arbiter_if.slave bus
);
    import rob_wb_arbiter_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                         ptr_q, ptr_d;
    logic [WB_WIDTH-1:0]                      wb_en_q, wb_en_d;
    logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]  wb_rob_addr_q, wb_rob_addr_d;
    logic [WB_WIDTH-1:0][BANK_ADDR_WIDTH-1:0] wb_bank_addr_q, wb_bank_addr_d;

    logic [WB_WIDTH-1:0][NUM_REQ-1:0] port_sel;
    logic [WB_WIDTH-1:0]              port_valid;
    logic [PTR_W-1:0]                 last_idx;
    logic                             any_grant;

    rob_wb_arbiter_rr_multi_picker #(
        .NUM_REQ  (NUM_REQ),
        .WB_WIDTH (WB_WIDTH)
    ) u_picker (
        .req        (bus.req_valid),
        .ptr        (ptr_q),
        .port_sel   (port_sel),
        .port_valid (port_valid),
        .last_idx   (last_idx),
        .any_grant  (any_grant)
    );

    // Grants are masked by flush and reset but never look at the payload.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int p = 0; p < WB_WIDTH; p++) begin
                    bus.req_ready[i] = bus.req_ready[i] | port_sel[p][i];
                end
            end
        end
    end

    always_comb begin
        wb_en_d        = '0;
        wb_rob_addr_d  = '0;
        wb_bank_addr_d = '0;
        ptr_d          = ptr_q;
        if (!flush) begin
            wb_en_d = port_valid;
            for (int p = 0; p < WB_WIDTH; p++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (port_sel[p][i]) begin
                        wb_rob_addr_d[p]  = bus.req_rob_addr[i];
                        wb_bank_addr_d[p] = bus.req_bank_addr[i];
                    end
                end
            end
            if (any_grant) begin
                ptr_d = PTR_W'(next_idx(int'(last_idx), NUM_REQ));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            wb_en_q        <= '0;
            wb_rob_addr_q  <= '0;
            wb_bank_addr_q <= '0;
        end else begin
            ptr_q          <= ptr_d;
            wb_en_q        <= wb_en_d;
            wb_rob_addr_q  <= wb_rob_addr_d;
            wb_bank_addr_q <= wb_bank_addr_d;
        end
    end

    assign bus.wb_en        = wb_en_q;
    assign bus.wb_rob_addr  = wb_rob_addr_q;
    assign bus.wb_bank_addr = wb_bank_addr_q;

`ifdef ROB_WB_ARB_PERF_EN
    logic [31:0] perf_grant_cnt_q, perf_grant_cnt_d;
    logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;

    // A cycle can add up to WB_WIDTH grants, so the sum carries one extra bit for saturation.
    always_comb begin
        logic [32:0] grant_sum;
        perf_grant_cnt_d    = perf_grant_cnt_q;
        perf_conflict_cnt_d = perf_conflict_cnt_q;
        grant_sum = {1'b0, perf_grant_cnt_q} + 33'(count_ones(32'(port_valid)));
        if (!flush) begin
            perf_grant_cnt_d = grant_sum[32] ? '1 : grant_sum[31:0];
            if (count_ones(32'(bus.req_valid)) > WB_WIDTH && perf_conflict_cnt_q != '1) begin
                perf_conflict_cnt_d = perf_conflict_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant_cnt_q    <= '0;
            perf_conflict_cnt_q <= '0;
        end else begin
            perf_grant_cnt_q    <= perf_grant_cnt_d;
            perf_conflict_cnt_q <= perf_conflict_cnt_d;
        end
    end

    assign perf_grant_cnt    = perf_grant_cnt_q;
    assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

`ifndef SYNTHESIS
    // Two ports writing the same ROB entry in one cycle means upstream issued a duplicate.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            for (int p = 0; p < WB_WIDTH; p++) begin
                for (int q = p + 1; q < WB_WIDTH; q++) begin
                    assert (!(wb_en_d[p] && wb_en_d[q] &&
                              wb_rob_addr_d[p] == wb_rob_addr_d[q] &&
                              wb_bank_addr_d[p] == wb_bank_addr_d[q]))
                    else $warning("rob_wb_arbiter: duplicate writeback target on ports %0d and %0d", p, q);
                end
            end
        end
    end
`endif

endmodule
